// File: rtl/paddsb_pkg.sv
// Shared lane geometry, saturation limits and beat types for the packed
// signed-add pipeline.
package paddsb_pkg;
  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = LANE_W * NUM_LANES;

  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

  typedef logic [LANE_W-1:0]    lane_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;

  typedef struct packed {
    data_t a;
    data_t b;
    logic  sub;
  } operand_t;
endpackage

// File: rtl/paddsb_if.sv
// Operand and result handshake bundle; the master drives operands and
// accepts results, the slave is the pipeline.
interface paddsb_if;
  import paddsb_pkg::*;

  logic       in_valid;
  logic       in_ready;
  data_t      a;
  data_t      b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  data_t      sum;
  lane_mask_t lane_ovfl;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, lane_ovfl
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, lane_ovfl
  );
endinterface

// File: rtl/paddsb_lane.sv
// One combinational signed lane: add or subtract with overflow detect.
// Defining PADDSB_SAT_EN clamps overflowed lanes instead of wrapping.
module paddsb_lane
  import paddsb_pkg::*;
(
  input  lane_t a,
  input  lane_t b,
  input  logic  sub,
  output lane_t result,
  output logic  ovfl
);
  lane_t b_eff;
  lane_t raw;

  // Subtraction is a + ~b + 1, so overflow is judged on the inverted operand.
  assign b_eff = sub ? ~b : b;
  assign raw   = a + b_eff + {{(LANE_W-1){1'b0}}, sub};
  assign ovfl  = (a[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);

`ifdef PADDSB_SAT_EN
  assign result = ovfl ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : raw;
`else
  assign result = raw;
`endif
endmodule

// File: rtl/paddsb_pipe.sv
// Two-stage packed signed add/subtract with valid/ready flow control and
// sticky per-lane overflow. Saturation build selected by PADDSB_SAT_EN.
module paddsb_pipe
  import paddsb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  paddsb_if.slave    bus,
  input  logic       clr_sticky,
  output lane_mask_t ovfl_sticky
);
  logic       s1_valid_reg;
  operand_t   s1_reg;
  logic       out_valid_reg;
  data_t      sum_reg;
  lane_mask_t lane_ovfl_reg;
  lane_mask_t sticky_reg;

  data_t      sum_next;
  lane_mask_t ovfl_next;
  logic       in_fire;
  logic       out_fire;
  logic       s2_load;

  assign out_fire     = out_valid_reg & bus.out_ready;
  assign s2_load      = s1_valid_reg & (~out_valid_reg | bus.out_ready);
  assign bus.in_ready = ~s1_valid_reg | ~out_valid_reg | bus.out_ready;
  assign in_fire      = bus.in_valid & bus.in_ready;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      paddsb_lane u_lane (
        .a      (s1_reg.a[gi*LANE_W +: LANE_W]),
        .b      (s1_reg.b[gi*LANE_W +: LANE_W]),
        .sub    (s1_reg.sub),
        .result (sum_next[gi*LANE_W +: LANE_W]),
        .ovfl   (ovfl_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_reg       <= '{a: bus.a, b: bus.b, sub: bus.sub};
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      lane_ovfl_reg <= '0;
    end else if (s2_load) begin
      out_valid_reg <= 1'b1;
      sum_reg       <= sum_next;
      lane_ovfl_reg <= ovfl_next;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end

  // A clear coinciding with a delivered beat keeps only that beat's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= '0;
    end else if (clr_sticky) begin
      sticky_reg <= out_fire ? lane_ovfl_reg : '0;
    end else if (out_fire) begin
      sticky_reg <= sticky_reg | lane_ovfl_reg;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.lane_ovfl = lane_ovfl_reg;
  assign ovfl_sticky   = sticky_reg;
endmodule

// File: tb/tb_paddsb_pipe.sv
// Scoreboard bench for paddsb_pipe: driver pushes model results, an
// independent monitor pops and compares on every output transfer.
module tb_paddsb_pipe;
  import paddsb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_sticky = 1'b0;
  lane_mask_t ovfl_sticky;

  paddsb_if bus();

  paddsb_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr_sticky  (clr_sticky),
    .ovfl_sticky (ovfl_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    data_t      sum;
    lane_mask_t ovfl;
  } exp_t;

  exp_t       exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  int         ready_mode = 1;   // 0 stall, 1 always ready, 2 random
  logic       clr_req = 1'b0;
  int         last_acc_cyc = 0;
  int         last_out_cyc = 0;
  data_t      last_sum = '0;
  lane_mask_t last_ovfl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: true signed lane arithmetic, range-checked.
  function automatic exp_t model(data_t a, data_t b, logic s);
    exp_t e;
    int   hi;
    int   lo;
    hi = (1 << (LANE_W - 1)) - 1;
    lo = -(1 << (LANE_W - 1));
    e.sum  = '0;
    e.ovfl = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic signed [LANE_W-1:0] la;
      logic signed [LANE_W-1:0] lb;
      int r;
      la = a[i*LANE_W +: LANE_W];
      lb = b[i*LANE_W +: LANE_W];
      r  = s ? int'(la) - int'(lb) : int'(la) + int'(lb);
      if (r > hi || r < lo) begin
        e.ovfl[i] = 1'b1;
`ifdef PADDSB_SAT_EN
        r = (r > hi) ? hi : lo;
`endif
      end
      e.sum[i*LANE_W +: LANE_W] = r[LANE_W-1:0];
    end
    return e;
  endfunction

  // Monitor: drives out_ready/clr_sticky, pops and compares, tracks sticky.
  initial begin
    exp_t       e;
    lane_mask_t exp_sticky = '0;
    logic       held_v = 1'b0;
    data_t      held_sum = '0;
    lane_mask_t held_ovfl = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_mode == 2) begin
        bus.out_ready = ($urandom % 3) != 0;
        clr_sticky    = ($urandom % 20) == 0;
      end else begin
        bus.out_ready = (ready_mode == 1);
        clr_sticky    = clr_req;
      end
      #1;
      if (!rst_n) begin
        exp_q.delete();
        exp_sticky = '0;
        held_v     = 1'b0;
        continue;
      end
      check("ovfl_sticky", ovfl_sticky, exp_sticky);
      if (held_v) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_sum", bus.sum, held_sum);
        check("stall_ovfl", bus.lane_ovfl, held_ovfl);
      end
      held_v    = bus.out_valid && !bus.out_ready;
      held_sum  = bus.sum;
      held_ovfl = bus.lane_ovfl;
      if (bus.out_valid && bus.out_ready) begin
        last_out_cyc = cyc;
        last_sum     = bus.sum;
        last_ovfl    = bus.lane_ovfl;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got sum %h expected no output", bus.sum);
          e.ovfl = '0;
        end else begin
          e = exp_q.pop_front();
          check("sum", bus.sum, e.sum);
          check("lane_ovfl", bus.lane_ovfl, e.ovfl);
        end
        exp_sticky = clr_sticky ? e.ovfl : (exp_sticky | e.ovfl);
      end else if (clr_sticky) begin
        exp_sticky = '0;
      end
    end
  end

  task automatic send(data_t a, data_t b, logic s);
    int n = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back(model(a, b, s));
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    @(negedge clk); #2;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int   n;
    logic [15:0] exp_sum;
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    data_t exp_sum;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, 16'h0000);
    check("rst_sticky", ovfl_sticky, 4'h0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_out_valid", bus.out_valid, 1'b0);

    // Latency and directed values
    ready_mode = 1;
    send(16'h1234, 16'h1111, 1'b0);
    n = last_acc_cyc;
    wait_drain();
    check("latency", last_out_cyc - n, 2);
    check("dir_add_sum", last_sum, 16'h2345);
    check("dir_add_ovfl", last_ovfl, 4'h0);

`ifdef PADDSB_SAT_EN
    exp_sum = 16'h7777;
`else
    exp_sum = 16'h8888;
`endif
    send(16'h7777, 16'h1111, 1'b0);
    wait_drain();
    check("dir_posovf_sum", last_sum, exp_sum);
    check("dir_posovf_ovfl", last_ovfl, 4'hF);

`ifdef PADDSB_SAT_EN
    exp_sum = 16'h8888;
`else
    exp_sum = 16'h7777;
`endif
    send(16'h8888, 16'h1111, 1'b1);
    wait_drain();
    check("dir_negovf_sum", last_sum, exp_sum);
    check("dir_negovf_ovfl", last_ovfl, 4'hF);

    // Three back-to-back beats into a stalled output
    ready_mode = 0;
    fork
      begin
        send(16'h0123, 16'h0456, 1'b0);
        send(16'h1357, 16'h2468, 1'b1);
        send(16'hFEDC, 16'h0101, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #2;
        check("stall_in_ready", bus.in_ready, 1'b0);
        check("stall_in_valid", bus.in_valid, 1'b1);
        ready_mode = 1;
      end
    join
    wait_drain();

    // Randomized traffic with random backpressure and clears
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(data_t'($urandom), data_t'($urandom), logic'($urandom % 2));
    end
    ready_mode = 1;
    wait_drain();

    // Sticky clear coinciding with an overflowing transfer
    clr_req = 1'b1;
    @(negedge clk); #1;
    clr_req = 1'b0;
    send(16'h7007, 16'h1001, 1'b0);
    wait_drain();
    check("sticky_set", ovfl_sticky, 4'h9);
    ready_mode = 0;
    send(16'h0070, 16'h0010, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk); #2; n++;
    end
    check("sticky_pre_valid", bus.out_valid, 1'b1);
    check("sticky_pre_ovfl", bus.lane_ovfl, 4'h2);
    check("sticky_pre", ovfl_sticky, 4'h9);
    clr_req = 1'b1;
    ready_mode = 1;
    @(negedge clk); #1;
    clr_req = 1'b0;
    @(negedge clk); #2;
    check("sticky_clr_xfer", ovfl_sticky, 4'h2);

    // Asynchronous reset with two beats in flight
    ready_mode = 0;
    send(16'h7777, 16'h1111, 1'b0);
    send(16'h1234, 16'h1111, 1'b0);
    @(negedge clk); #3;
    check("inflight_sticky_before", ovfl_sticky, 4'h2);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 1'b0);
    check("async_sum", bus.sum, 16'h0000);
    check("async_lane_ovfl", bus.lane_ovfl, 4'h0);
    check("async_sticky", ovfl_sticky, 4'h0);
    check("async_in_ready", bus.in_ready, 1'b1);
    ready_mode = 1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("release_in_ready", bus.in_ready, 1'b1);
    check("release_out_valid", bus.out_valid, 1'b0);
    repeat (5) begin
      @(negedge clk); #2;
      check("no_stale_beat", bus.out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/paddsb_pipe.md
PADDSB_PIPE -- requirements
Module: paddsb_pipe

Interface
REQ-001 Parameters: none; lane width (4) and lane count (4) SHALL come from package constants only.
REQ-002 clk  input  1  single clock for the block; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block can accept operand beat.
REQ-006 a  input  16  four signed 4-bit lanes; lane i = a[4i+3:4i].
REQ-007 b  input  16  four signed 4-bit lanes, same packing.
REQ-008 sub  input  1  0 = per-lane a+b; 1 = per-lane a-b.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts result beat.
REQ-011 sum  output  16  per-lane result, same packing.
REQ-012 lane_ovfl  output  4  per-lane signed overflow for current result beat.
REQ-013 ovfl_sticky  output  4  per-lane accumulated overflow.
REQ-014 clr_sticky  input  1  clears ovfl_sticky.

Function
REQ-015 Transfers SHALL occur only on valid&ready in the same cycle; in: in_valid&in_ready, out: out_valid&out_ready.
REQ-016 Two register stages: S1 captures a, b, sub on input transfer; S2 holds computed sum, lane_ovfl.
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 beat/cycle.
REQ-018 S2 SHALL load when S1 valid and (~out_valid | out_ready); S1 SHALL load when ~S1valid | S1-to-S2 move.
REQ-019 in_ready SHALL be combinational: ~S1valid | (~out_valid | out_ready); no beat dropped, duplicated or reordered.
REQ-020 Lanes SHALL be independent: no carry crosses a lane boundary.
REQ-021 Subtract: effective b lane = ~b lane with lane carry-in 1; add: carry-in 0.
REQ-022 Lane overflow = operand sign bits equal (effective operands) and raw sum sign differs.
REQ-023 sum, lane_ovfl SHALL remain stable while out_valid & ~out_ready.
REQ-024 On each output transfer, ovfl_sticky |= lane_ovfl; clr_sticky clears it; simultaneous clr_sticky and overflowing output transfer -> ovfl_sticky = lane_ovfl of that beat.

Reset
REQ-025 rst_n low SHALL immediately clear S1valid, out_valid, sum=16'h0000, lane_ovfl=4'h0, ovfl_sticky=4'h0; in-flight beats discarded.
REQ-026 First cycle after rst_n release: in_ready=1, out_valid=0.

Configuration
REQ-027 Macro PADDSB_SAT_EN defined: overflowed lane SHALL saturate to 4'h7 (positive overflow) or 4'h8 (negative overflow).
REQ-028 PADDSB_SAT_EN undefined: lane result SHALL be the wrapped 4-bit sum; lane_ovfl and ovfl_sticky behave identically in both builds.

Structure
REQ-029 Package paddsb_pkg SHALL hold LANE_W=4, NUM_LANES=4, SAT_POS=4'h7, SAT_NEG=4'h8.
REQ-030 One sub-module paddsb_lane (combinational 4-bit lane: a, b, sub -> result, ovfl, saturation per macro) instantiated NUM_LANES times.

Verification
REQ-031 a=16'h1234, b=16'h1111, sub=0 -> sum=16'h2345, lane_ovfl=4'h0, out_valid exactly 2 cycles after accept.
REQ-032 a=16'h7777, b=16'h1111, sub=0 -> lane_ovfl=4'hF; sum=16'h7777 with PADDSB_SAT_EN, 16'h8888 without.
REQ-033 a=16'h8888, b=16'h1111, sub=1 -> lane_ovfl=4'hF; sum=16'h8888 with PADDSB_SAT_EN, 16'h7777 without.
REQ-034 Three back-to-back beats, out_ready low 5 cycles -> in_ready low once S1 and S2 full; all three results delivered in order, unchanged while stalled.
REQ-035 rst_n pulsed low with 2 beats in flight -> out_valid=0, sum=0, ovfl_sticky=0 asynchronously; no stale beat after release.
REQ-036 clr_sticky=1 in the cycle of an output transfer with lane_ovfl=4'h2 while ovfl_sticky=4'h9 -> ovfl_sticky=4'h2 next cycle.
